// File: rtl/par_to_serial_if.sv
// rtl/par_to_serial_if.sv - byte-in / serial-out bundle for par_to_serial
interface par_to_serial_if;
  logic [7:0] data_in_c;
  logic       valid_in_c;
  logic       ready_out_c;
  logic       data_out_s;
  logic       valid_frame_s;

  modport master (
    output data_in_c,
    output valid_in_c,
    input  ready_out_c,
    input  data_out_s,
    input  valid_frame_s
  );

  modport slave (
    input  data_in_c,
    input  valid_in_c,
    output ready_out_c,
    output data_out_s,
    output valid_frame_s
  );
endinterface

// File: rtl/par_to_serial.sv
// rtl/par_to_serial.sv - byte-to-serial framer, MSB first, comma fill and sync preamble
module par_to_serial #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         SYNC_FRAMES = 4
) (
  input  logic           clk8f,
  input  logic           reset,
  par_to_serial_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SYNC,
    ST_IDLE,
    ST_DATA
  } state_e;

  localparam logic [2:0] LAST_SYNC = 3'(SYNC_FRAMES - 1);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] sync_cnt_q, sync_cnt_d;
  logic       ready;
  logic       boundary;

  always_ff @(posedge clk8f) begin
    if (reset) begin
      state_q    <= ST_RESET;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      sync_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign boundary = (bit_cnt_q == 3'd7);

  // ready depends only on registered state so upstream never sees a combinational loop
  always_comb begin
    state_d    = state_q;
    shreg_d    = {shreg_q[6:0], 1'b0};
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    ready      = 1'b0;

    case (state_q)
      ST_RESET: begin
        shreg_d    = COMMA;
        bit_cnt_d  = 3'd0;
        sync_cnt_d = 3'd0;
        state_d    = ST_SYNC;
      end
      ST_SYNC: begin
        if (boundary) begin
          if (sync_cnt_q != LAST_SYNC) begin
            shreg_d    = COMMA;
            sync_cnt_d = sync_cnt_q + 3'd1;
          end else begin
            ready = 1'b1;
          end
        end
      end
      ST_IDLE, ST_DATA: begin
        if (boundary) ready = 1'b1;
      end
      default: state_d = ST_RESET;
    endcase

    if (ready) begin
      if (bus.valid_in_c) begin
        shreg_d = bus.data_in_c;
        state_d = ST_DATA;
      end else begin
        shreg_d = COMMA;
        state_d = ST_IDLE;
      end
    end
  end

  assign bus.ready_out_c   = ready;
  assign bus.data_out_s    = shreg_q[7];
  assign bus.valid_frame_s = (state_q == ST_DATA);

endmodule

// File: tb/tb_par_to_serial.sv
// tb/tb_par_to_serial.sv - directed self-checking bench for par_to_serial
module tb_par_to_serial;
  logic clk8f = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  par_to_serial_if bus ();

  par_to_serial #(.COMMA(8'hBC), .SYNC_FRAMES(4)) dut (
    .clk8f (clk8f),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk8f = ~clk8f;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk8f);
    @(negedge clk8f);
  endtask

  // Checks one 8-cycle frame starting at bit_cnt==0; inputs are whatever the caller set.
  task automatic frame(input string tag, input logic [7:0] exp_byte, input logic exp_vf,
                       input logic exp_rdy);
    logic [7:0] b;
    b = exp_byte;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s.bit%0d", tag, i), bus.data_out_s, b[7-i]);
      chk($sformatf("%s.vf%0d", tag, i), bus.valid_frame_s, exp_vf);
      chk($sformatf("%s.rdy%0d", tag, i), bus.ready_out_c, (i == 7) ? exp_rdy : 1'b0);
      step();
    end
  endtask

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;
    reset          = 1'b1;
    bus.valid_in_c = 1'b0;
    bus.data_in_c  = 8'h00;
    step();
    step();
    chk("rst.data", bus.data_out_s, 1'b0);
    chk("rst.rdy", bus.ready_out_c, 1'b0);
    chk("rst.vf", bus.valid_frame_s, 1'b0);

    // release: four sync commas, first ready at cycle 31, then idle commas every 8
    reset = 1'b0;
    step();
    frame("sync0", 8'hBC, 1'b0, 1'b0);
    frame("sync1", 8'hBC, 1'b0, 1'b0);
    frame("sync2", 8'hBC, 1'b0, 1'b0);
    frame("sync3", 8'hBC, 1'b0, 1'b1);
    frame("idle0", 8'hBC, 1'b0, 1'b1);

    // back-to-back A5, 3C
    bus.valid_in_c = 1'b1;
    bus.data_in_c  = 8'hA5;
    frame("idle1", 8'hBC, 1'b0, 1'b1);
    bus.data_in_c  = 8'h3C;
    frame("dA5", 8'hA5, 1'b1, 1'b1);
    bus.valid_in_c = 1'b0;
    frame("d3C", 8'h3C, 1'b1, 1'b1);
    frame("idle2", 8'hBC, 1'b0, 1'b1);

    // one-cycle valid pulse at bit_cnt==3 is ignored
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pulse.bit%0d", i), bus.data_out_s, (8'hBC >> (7 - i)) & 8'h01);
      chk($sformatf("pulse.vf%0d", i), bus.valid_frame_s, 1'b0);
      bus.valid_in_c = (i == 3);
      bus.data_in_c  = 8'hFF;
      step();
    end
    bus.valid_in_c = 1'b0;
    frame("postpulse", 8'hBC, 1'b0, 1'b1);

    // data byte equal to comma
    bus.valid_in_c = 1'b1;
    bus.data_in_c  = 8'hBC;
    frame("idle3", 8'hBC, 1'b0, 1'b1);
    bus.valid_in_c = 1'b0;
    frame("dBC", 8'hBC, 1'b1, 1'b1);
    frame("idle4", 8'hBC, 1'b0, 1'b1);

    // reset at bit_cnt==4 of a C3 frame
    bus.valid_in_c = 1'b1;
    bus.data_in_c  = 8'hC3;
    frame("idle5", 8'hBC, 1'b0, 1'b1);
    bus.valid_in_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dC3.bit%0d", i), bus.data_out_s, c3[7-i]);
      chk($sformatf("dC3.vf%0d", i), bus.valid_frame_s, 1'b1);
      if (i == 4) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    chk("abort.data", bus.data_out_s, 1'b0);
    chk("abort.vf", bus.valid_frame_s, 1'b0);
    chk("abort.rdy", bus.ready_out_c, 1'b0);
    step();
    frame("resync0", 8'hBC, 1'b0, 1'b0);
    frame("resync1", 8'hBC, 1'b0, 1'b0);
    frame("resync2", 8'hBC, 1'b0, 1'b0);
    frame("resync3", 8'hBC, 1'b0, 1'b1);
    frame("idle6", 8'hBC, 1'b0, 1'b1);

    // valid held through the sync preamble: accepted only at the first ready cycle
    reset = 1'b1;
    step();
    reset          = 1'b0;
    bus.valid_in_c = 1'b1;
    bus.data_in_c  = 8'h12;
    step();
    frame("esync0", 8'hBC, 1'b0, 1'b0);
    frame("esync1", 8'hBC, 1'b0, 1'b0);
    frame("esync2", 8'hBC, 1'b0, 1'b0);
    frame("esync3", 8'hBC, 1'b0, 1'b1);
    bus.valid_in_c = 1'b0;
    frame("d12", 8'h12, 1'b1, 1'b1);
    frame("idle7", 8'hBC, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/par_to_serial.md
PAR_TO_SERIAL -- requirements
Module: par_to_serial

Interface
REQ-001 The block SHALL have parameter COMMA, default 8'hBC, the idle/sync symbol (K28.5) sent when no data byte is accepted.
REQ-002 The block SHALL have parameter SYNC_FRAMES, default 4, the number of comma frames sent after reset before any data is accepted (legal range 1..8).
REQ-003 The block SHALL have port clk8f, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 The block SHALL have port data_in_c, input, 8 bits, the byte from the upstream 2:1 mux output.
REQ-006 The block SHALL have port valid_in_c, input, 1 bit, marking data_in_c as valid.
REQ-007 The block SHALL have port ready_out_c, output, 1 bit, high in the single cycle where a byte is accepted.
REQ-008 The block SHALL have port data_out_s, output, 1 bit, the serial line, MSB first.
REQ-009 The block SHALL have port valid_frame_s, output, 1 bit, high for all 8 bit-cycles of a data frame.

Function
REQ-010 The block SHALL hold an 8-bit shift register shreg, a 3-bit bit counter bit_cnt, a sync-frame counter sync_cnt and a state register.
REQ-011 The state machine SHALL have exactly four states: RESET, SYNC, IDLE and DATA.
REQ-012 data_out_s SHALL equal shreg[7] at all times, so it is a direct register output with no combinational path from the inputs.
REQ-013 The cycle where bit_cnt==7 SHALL be the frame boundary, and on the edge that ends it shreg SHALL reload and bit_cnt SHALL wrap to 0.
REQ-014 On every other non-reset edge, shreg SHALL shift left with LSB filled 0 and bit_cnt SHALL increment by 1.
REQ-015 The first non-reset edge after RESET SHALL load shreg=COMMA, set bit_cnt=0 and sync_cnt=0, and enter SYNC.
REQ-016 In SYNC, each frame boundary where sync_cnt<SYNC_FRAMES-1 SHALL reload COMMA, increment sync_cnt and stay in SYNC.
REQ-017 ready_out_c SHALL be 1 exactly when bit_cnt==7 and either the state is IDLE or DATA, or the state is SYNC with sync_cnt==SYNC_FRAMES-1; it SHALL be 0 otherwise.
REQ-018 ready_out_c SHALL be a function of state only and SHALL NOT depend on valid_in_c.
REQ-019 On an edge with ready_out_c=1 and valid_in_c=1, the block SHALL load shreg=data_in_c and go to DATA.
REQ-020 On an edge with ready_out_c=1 and valid_in_c=0, the block SHALL load shreg=COMMA and go to IDLE, and data_in_c SHALL be ignored.
REQ-021 valid_in_c and data_in_c SHALL be ignored in every cycle where ready_out_c=0, so no byte is buffered or held pending.
REQ-022 Latency SHALL be: a byte accepted at edge E drives its bit 7 on data_out_s in the cycle after E and its bit 0 seven cycles later.
REQ-023 valid_frame_s SHALL be 1 exactly when the state is DATA, so it aligns with the 8 serial bit-cycles of each data byte.
REQ-024 Back-to-back valid bytes SHALL serialize with no gap, giving 8 cycles per byte and a throughput of 1 byte per 8 clk8f cycles.
REQ-025 A valid byte equal to COMMA SHALL be sent as data with valid_frame_s=1, with no escaping.
REQ-026 A valid_in_c that goes high mid-frame SHALL NOT be accepted until the next bit_cnt==7 cycle, and only if it is still high in that cycle.

Reset
REQ-027 While reset is sampled high, the block SHALL drive state=RESET, shreg=8'h00, bit_cnt=0, sync_cnt=0, data_out_s=0, ready_out_c=0 and valid_frame_s=0.
REQ-028 Reset asserted mid-frame in any state SHALL abort that frame at the next edge, discard any partial byte and restart the full SYNC_FRAMES comma sequence after release.
REQ-029 The block SHALL have no asynchronous reset path, and the initial value before the first clock SHALL be don't-care.

Verification
REQ-030 Reset release with valid_in_c=0 held -> data_out_s carries 10111100 repeated, with ready_out_c first high in cycle 32 after release (0-based index 31), then every 8 cycles, and valid_frame_s=0 throughout.
REQ-031 After sync, valid_in_c=1 held with data 8'hA5 then 8'h3C at consecutive ready cycles -> serial 10100101 00111100 with no gap, and valid_frame_s=1 for 16 cycles.
REQ-032 valid_in_c pulsed high for one cycle at bit_cnt==3 with 8'hFF -> the byte is not accepted, the line stays at comma and valid_frame_s stays 0.
REQ-033 valid_in_c=1 with 8'h12 during the SYNC frames before the final ready cycle -> the byte is ignored, and it is accepted only at the first ready cycle, appearing as serial 00010010.
REQ-034 reset pulsed high for 1 cycle at bit_cnt==4 of a data frame for 8'hC3 -> the frame is truncated, and 4 full comma frames follow before the next ready_out_c.
REQ-035 valid byte 8'hBC sent -> serial 10111100 with valid_frame_s=1, distinguishable from an idle comma only by valid_frame_s.
